// File: rtl/seq_divider_32bit_if.sv
// Handshake and operand/result bundle for seq_divider_32bit.
// The divider connects through the slave modport and its producer/consumer through master.
interface seq_divider_32bit_if #(
  parameter int DW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            is_signed;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;
  logic            busy;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/seq_divider_32bit.sv
// Radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to build the signed path; otherwise is_signed is ignored.
module seq_divider_32bit #(
  parameter int DW = 32
) (
  input logic                clk,
  input logic                rst,
  seq_divider_32bit_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2*DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   quotient_q, quotient_d;
  logic [DW-1:0]   remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
  logic            signed_q, signed_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
`endif

  logic [2*DW-1:0] dvd_mag;
  logic [DW-1:0]   dvs_mag;
  logic [DW+1:0]   t_diff;

  // During CALC dvd_q holds {partial remainder, dividend bits}; quotient bits
  // enter at the LSB so after DW steps the low half is the quotient magnitude.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
`ifdef SEQ_DIV_SIGNED_EN
    signed_d    = signed_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif
    dvd_mag     = dvd_q;
    dvs_mag     = dvs_q;
`ifdef SEQ_DIV_SIGNED_EN
    if (signed_q && dvd_q[2*DW-1]) dvd_mag = -dvd_q;
    if (signed_q && dvs_q[DW-1])   dvs_mag = -dvs_q;
`endif
    t_diff = {1'b0, dvd_q[2*DW-1:DW], dvd_q[DW-1]} - {2'b00, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d    = bus.dividend;
          dvs_d    = bus.divisor;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
          signed_d = bus.is_signed;
`endif
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d = '0;
        if (dvs_q == '0) begin
          dbz_d       = 1'b1;
          quotient_d  = '1;
          remainder_d = dvd_q[DW-1:0];
          state_d     = S_DONE;
        end else if (dvd_mag[2*DW-1:DW] >= dvs_mag) begin
          ovf_d       = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = S_DONE;
        end else begin
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
`ifdef SEQ_DIV_SIGNED_EN
          q_neg_d = signed_q & (dvd_q[2*DW-1] ^ dvs_q[DW-1]);
          r_neg_d = signed_q & dvd_q[2*DW-1];
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!t_diff[DW+1]) begin
          dvd_d = {t_diff[DW-1:0], dvd_q[DW-2:0], 1'b1};
        end else begin
          dvd_d = {dvd_q[2*DW-2:0], 1'b0};
        end
        if (cnt_q == CW'(DW-1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        quotient_d  = dvd_q[DW-1:0];
        remainder_d = dvd_q[2*DW-1:DW];
`ifdef SEQ_DIV_SIGNED_EN
        if (q_neg_q) quotient_d  = -dvd_q[DW-1:0];
        if (r_neg_q) remainder_d = -dvd_q[2*DW-1:DW];
        // A negative result may reach 2^(DW-1); a positive one must stay below it.
        if (signed_q && (q_neg_q ? (dvd_q[DW-1:0] > {1'b1, {(DW-1){1'b0}}})
                                 : dvd_q[DW-1])) begin
          ovf_d       = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
        end
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      signed_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
      signed_q    <= signed_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider_32bit.sv
// Randomized self-checking bench for seq_divider_32bit against a wide-arithmetic reference model.
// Follows SEQ_DIV_SIGNED_EN: when undefined the model treats every operation as unsigned.
module tb_seq_divider_32bit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_divider_32bit_if #(.DW(32)) bus ();

  seq_divider_32bit #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  // Expected result from the arithmetic definition: truncating division on wide signed integers.
  function automatic exp_t refModel(input logic [63:0] dvd, input logic [31:0] dvs, input logic sgn);
    exp_t e;
    logic signed [127:0] a, b, qt, rt, lo, hi, qabs;
    logic s;
    s = sgn;
`ifndef SEQ_DIV_SIGNED_EN
    s = 1'b0;
`endif
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 34;
    e.q   = '0;
    e.r   = '0;
    if (dvs == 32'd0) begin
      e.dbz = 1'b1;
      e.q   = 32'hFFFF_FFFF;
      e.r   = dvd[31:0];
      e.lat = 1;
      return e;
    end
    if (s) begin
      a  = {{64{dvd[63]}}, dvd};
      b  = {{96{dvs[31]}}, dvs};
      lo = -128'sd2147483648;
      hi = 128'sd2147483647;
    end else begin
      a  = {64'd0, dvd};
      b  = {96'd0, dvs};
      lo = 128'sd0;
      hi = 128'sd4294967295;
    end
    qt   = a / b;
    rt   = a % b;
    qabs = (qt < 0) ? -qt : qt;
    if (qabs >= 128'sd4294967296) e.lat = 1;
    if (qt < lo || qt > hi) begin
      e.ovf = 1'b1;
    end else begin
      e.q = qt[31:0];
      e.r = rt[31:0];
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs, input logic sgn,
                               input int hold, input string tag);
    exp_t e;
    int   n;
    e = refModel(dvd, dvs, sgn);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.dividend  = ~dvd;
    bus.divisor   = ~dvs;
    bus.is_signed = ~sgn;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(e.lat));
    checkOutput({tag, "_quot"}, 64'(bus.quotient), 64'(e.q));
    checkOutput({tag, "_rem"}, 64'(bus.remainder), 64'(e.r));
    checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
    checkOutput({tag, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      checkOutput({tag, "_hold_busy"}, 64'({bus.in_ready, bus.busy}), 64'b01);
      checkOutput({tag, "_hold_quot"}, 64'(bus.quotient), 64'(e.q));
      checkOutput({tag, "_hold_rem"}, 64'(bus.remainder), 64'(e.r));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_released"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  logic [63:0] dvd;
  logic [31:0] dvs, hi32, lo32;
  logic        sgn;
  int          sel;
  int          vcount;

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    #2;
    checkOutput("reset_ready", 64'({bus.in_ready, bus.busy, bus.out_valid}), 64'b100);
    checkOutput("reset_quot", 64'(bus.quotient), 64'd0);
    checkOutput("reset_rem", 64'(bus.remainder), 64'd0);
    checkOutput("reset_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(64'd100, 32'd7, 1'b0, 2, "u100_7");
    applyStimulus(-64'sd100, 32'd7, 1'b1, 0, "sneg100_7");
    applyStimulus(64'd100, -32'sd7, 1'b1, 1, "s100_neg7");
    applyStimulus(64'h0000_0000_DEAD_BEEF, 32'd0, 1'b0, 1, "dbz");
    applyStimulus(64'h0000_0001_0000_0000, 32'd1, 1'b0, 0, "uovf");
    applyStimulus(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "sovf");
    applyStimulus(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, 0, "smin_1");
    applyStimulus(64'h0000_0000_8000_0000, 32'd1, 1'b1, 0, "sovf_pos");
    applyStimulus(64'h0000_0000_FFFF_FFFF, 32'd1, 1'b0, 0, "umax_1");
    applyStimulus(64'h8000_0000_0000_0000, 32'h8000_0000, 1'b1, 0, "smin_smin");
    applyStimulus(64'h1234_5678 * 64'h9ABC_DEF0, 32'h9ABC_DEF0, 1'b0, 10, "roundtrip");

    for (int k = 0; k < 60; k++) begin
      hi32 = $urandom;
      lo32 = $urandom;
      dvs  = $urandom;
      sgn  = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 4);
      case (sel)
        0: dvd = {hi32, lo32};
        1: dvd = {((dvs != 0) ? hi32 % dvs : hi32), lo32};
        2: dvd = {{32{lo32[31]}}, lo32};
        3: begin
          dvs = 32'($urandom_range(1, 15));
          if (hi32[0]) dvs = -dvs;
          dvd = {{32{lo32[31]}}, lo32};
        end
        default: begin
          dvs = 32'd0;
          dvd = {hi32, lo32};
        end
      endcase
      applyStimulus(dvd, dvs, sgn, $urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    // Abandon an operation mid-CALC; no result may appear afterwards.
    bus.dividend  = 64'd100;
    bus.divisor   = 32'd7;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("midreset_state", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    checkOutput("midreset_quot", 64'(bus.quotient), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    checkOutput("midreset_no_valid", 64'(vcount), 64'd0);
    applyStimulus(64'd1000, 32'd33, 1'b0, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
